// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and constants for the sequential divider
package divider_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

endpackage

// File: rtl/addsub9.sv
// rtl/addsub9.sv - ripple adder/subtractor built from full-adder cells
// cin=1 selects subtract: B is inverted and the carry-in supplies the +1.
module addsub9 #(
  parameter int N = 9
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  output logic [N-1:0] S,
  output logic         cout
);

  logic [N:0]   carry;
  logic [N-1:0] b_eff;

  assign carry[0] = cin;
  assign b_eff    = B ^ {N{cin}};

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign S[i]       = A[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1] = (A[i] & b_eff[i]) | (carry[i] & (A[i] ^ b_eff[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per clock
// Start/Done handshake; results publish only on completion.
module seq_divider #(
  parameter int WIDTH = divider_pkg::WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  divider_pkg::div_state_t state;

  logic [WIDTH:0]   a;
  logic [WIDTH:0]   m;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;

  logic [2*WIDTH:0] aq_shl;
  logic [WIDTH:0]   ash;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             no_borrow;

  // A's top bit is always 0 between iterations, so it falls off the shift.
  assign aq_shl = {a, q} << 1;
  assign ash    = aq_shl[2*WIDTH:WIDTH];

  addsub9 #(.N(WIDTH + 1)) u_trial (
    .A   (ash),
    .B   (m),
    .cin (1'b1),
    .S   (trial),
    .cout(no_borrow)
  );

  assign a_next = no_borrow ? trial : ash;
  assign q_next = aq_shl[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, no_borrow};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= divider_pkg::IDLE;
      a         <= '0;
      m         <= '0;
      q         <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        divider_pkg::IDLE: begin
          if (Start) begin
            a     <= '0;
            q     <= Dividend;
            m     <= {1'b0, Divisor};
            count <= '0;
            if (Divisor == '0) begin
              state     <= divider_pkg::DONE;
              Done      <= 1'b1;
              Quotient  <= '1;
              Remainder <= Dividend;
              DivByZero <= 1'b1;
            end else begin
              state <= divider_pkg::RUN;
              Busy  <= 1'b1;
            end
          end
        end
        divider_pkg::RUN: begin
          a     <= a_next;
          q     <= q_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            state     <= divider_pkg::DONE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            Quotient  <= q_next;
            Remainder <= a_next[WIDTH-1:0];
            DivByZero <= 1'b0;
          end
        end
        divider_pkg::DONE: begin
          // Waiting for Start to drop keeps a held Start to one operation.
          if (!Start) begin
            state <= divider_pkg::IDLE;
            Done  <= 1'b0;
          end
        end
        default: begin
          state <= divider_pkg::IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
